mux_scan: RTL and testbench
===========================

Name: mux_scan

Overview:
- Parametrised successor to the fixed 7-channel counter-readout mux.
- Selects one of N_CH gray-counter channels (each with an A/B counter pair and roll flags) and registers that channel's payload for the output pins.
- Adds three capabilities: a direct priority-select mode, an automatic round-robin scan mode with programmable dwell, and a snapshot mode with a valid/ready handshake.
- Sits between the counter bank and the top-level output pin packing.

Parameters:
- N_CH, 7, number of channels. Channel 0 is the default/clock channel. Must be ≥ 2.
- CNT_W, 5, width of each A/B counter.
- DWELL_W, 8, width of the scan dwell count.
- CH_W, $clog2(N_CH), width of the channel index.
- P_W, 2*CNT_W+2, payload width (derived; not overridden).

Ports:
- i_clk  in  1  system clock, all logic on posedge.
- i_rst  in  1  synchronous, active-high reset.
- i_mode  in  2  0 = direct, 1 = scan, 2 = snapshot, 3 = reserved (treated as direct).
- i_sel  in  N_CH-1  priority select. Bit k-1 selects channel k; the highest set bit wins; all-zero selects channel 0.
- i_dwell  in  DWELL_W  scan dwell in cycles per channel. 0 is treated as 1.
- i_roll_a  in  N_CH  A roll flag per channel.
- i_roll_b  in  N_CH  B roll flag per channel.
- i_cnt_a  in  N_CH*CNT_W  A counters, flattened; channel k at [k*CNT_W +: CNT_W].
- i_cnt_b  in  N_CH*CNT_W  B counters, same packing as i_cnt_a.
- i_req  in  1  snapshot request (snapshot mode only).
- i_ready  in  1  consumer ready (snapshot mode only).
- o_data  out  P_W  payload {roll_b, cnt_b, roll_a, cnt_a} of the chosen channel.
- o_ch  out  CH_W  index of the channel in o_data.
- o_valid  out  1  o_data qualifier (meaning per mode).
- o_ovf  out  1  sticky: a snapshot request was dropped.

Behaviour:
- Reset: o_data=0, o_ch=0, o_valid=0, o_ovf=0, scan index=0, dwell counter=0, state=DIRECT. i_rst overrides all other inputs.
- Priority encoder (combinational): sel_ch = index of the highest set bit of i_sel, plus 1; 0 when i_sel=0.
- States: DIRECT, SCAN, SNAP_IDLE, SNAP_HOLD.
  - Each cycle, if i_mode maps to a different state family than the current state, the next state is that family's entry state: DIRECT, SCAN, or SNAP_IDLE.
  - On any such mode change: scan index=0, dwell counter=0, o_valid=0, o_ovf cleared.
- DIRECT:
  - Every cycle: o_data <= payload(sel_ch), o_ch <= sel_ch, o_valid <= 1.
  - Latency is 1 cycle from an i_sel or counter change to the output.
- SCAN:
  - i_sel is ignored.
  - Every cycle: o_data <= payload(scan index), o_ch <= scan index.
  - Dwell counter increments each cycle. When it reaches max(i_dwell,1)-1 it returns to 0 and the scan index advances; the index wraps from N_CH-1 to 0.
  - o_valid is 1 only on the first output cycle of each channel's dwell.
  - Changing i_dwell mid-dwell takes effect on the next comparison; if the counter already exceeds the new limit-1, advance immediately.
- SNAP_IDLE:
  - o_valid=0 and o_data holds its last value.
  - i_req=1: capture o_data <= payload(sel_ch) and o_ch <= sel_ch, set o_valid=1, go to SNAP_HOLD. Capture is 1 cycle after i_req.
- SNAP_HOLD:
  - o_data and o_ch are stable; o_valid=1.
  - i_ready=1: o_valid <= 0 next cycle, go to SNAP_IDLE.
  - i_req=1 while in SNAP_HOLD, including the same cycle as i_ready: request is dropped and o_ovf <= 1.
  - o_ovf stays set until reset or a mode change.
- Reset asserted mid-scan or mid-hold: everything returns to reset values the next edge and the pending snapshot is discarded.
- Payload bit positions: cnt_a at [CNT_W-1:0], roll_a at [CNT_W], cnt_b at [2*CNT_W:CNT_W+1], roll_b at [P_W-1].

Test Plan:
- Reset, mode=0, i_sel=0, ch0 cnt_a=5'h15, cnt_b=5'h0A, roll_a=1, roll_b=0 -> next cycle o_data=12'h15 | (1<<5) | (12'h0A<<6) = 12'h2B5, o_ch=0, o_valid=1.
- Mode=0, i_sel=6'b010100 -> o_ch=5. Then i_sel=6'b100000 -> o_ch=6 after 1 cycle.
- Mode=1, i_dwell=3, N_CH=7 -> o_ch sequence 0,0,0,1,1,1,…,6,6,6,0. o_valid high on each first cycle only. i_dwell=0 -> o_ch advances every cycle.
- Mode=2, i_sel=6'b000010 (ch2), i_req pulse, i_ready=0 -> o_valid=1, o_ch=2, o_data frozen while ch2 counters change. Then i_ready=1 -> o_valid=0 next cycle.
- Mode=2 in SNAP_HOLD, second i_req -> o_ovf=1 and o_data unchanged. Switch to mode 0 -> o_ovf=0.
- Mode=1 mid-dwell at ch4, assert i_rst for 1 cycle -> o_data=0, o_ch=0, o_valid=0. After release, scan restarts at ch0 with a full dwell.

Source files
------------

// File: rtl/mux_scan.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan
// Description : Counter-readout multiplexer for N_CH gray-counter channels.
//               Picks one channel's {roll_b, cnt_b, roll_a, cnt_a} payload
//               and registers it for the output pins. There are three modes:
//               direct priority select, round-robin scan with programmable
//               dwell, and snapshot with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   i_clk      system clock, posedge
//   i_rst      synchronous active-high reset
//   i_mode     0 direct, 1 scan, 2 snapshot, 3 reserved (acts as direct)
//   i_sel      priority select, bit k-1 -> channel k, highest bit wins
//   i_dwell    scan dwell in cycles per channel (0 acts as 1)
//   i_roll_a   A roll flag per channel
//   i_roll_b   B roll flag per channel
//   i_cnt_a    A counters, channel k at [k*CNT_W +: CNT_W]
//   i_cnt_b    B counters, same packing
//   i_req      snapshot request
//   i_ready    snapshot consumer ready
//   o_data     registered payload of the chosen channel
//   o_ch       index of the channel held in o_data
//   o_valid    o_data qualifier (meaning depends on mode)
//   o_ovf      sticky flag: a snapshot request was dropped
// ============================================================================
module mux_scan #(
    parameter  int N_CH    = 7,
    parameter  int CNT_W   = 5,
    parameter  int DWELL_W = 8,
    parameter  int CH_W    = $clog2(N_CH),
    localparam int P_W     = 2*CNT_W + 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_mode,
    input  logic [N_CH-2:0]       i_sel,
    input  logic [DWELL_W-1:0]    i_dwell,
    input  logic [N_CH-1:0]       i_roll_a,
    input  logic [N_CH-1:0]       i_roll_b,
    input  logic [N_CH*CNT_W-1:0] i_cnt_a,
    input  logic [N_CH*CNT_W-1:0] i_cnt_b,
    input  logic                  i_req,
    input  logic                  i_ready,
    output logic [P_W-1:0]        o_data,
    output logic [CH_W-1:0]       o_ch,
    output logic                  o_valid,
    output logic                  o_ovf
);

    typedef enum logic [1:0] {
        ST_DIRECT    = 2'd0,
        ST_SCAN      = 2'd1,
        ST_SNAP_IDLE = 2'd2,
        ST_SNAP_HOLD = 2'd3
    } state_t;

    // Mode families; both snapshot states belong to the same family.
    localparam logic [1:0] c_FAM_DIRECT = 2'd0;
    localparam logic [1:0] c_FAM_SCAN   = 2'd1;
    localparam logic [1:0] c_FAM_SNAP   = 2'd2;

    state_t               r_state_q, w_state_d;
    logic [CH_W-1:0]      r_idx_q,   w_idx_d;
    logic [DWELL_W-1:0]   r_dwell_q, w_dwell_d;
    logic [P_W-1:0]       r_data_q,  w_data_d;
    logic [CH_W-1:0]      r_ch_q,    w_ch_d;
    logic                 r_valid_q, w_valid_d;
    logic                 r_ovf_q,   w_ovf_d;

    logic [P_W-1:0]       w_pay [N_CH];
    logic [CH_W-1:0]      w_sel_ch;
    logic [1:0]           w_req_fam;
    logic [1:0]           w_cur_fam;
    logic [DWELL_W-1:0]   w_dwell_last;
    logic                 w_dwell_done;

    // Per-channel payload assembly.
    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_pay
            assign w_pay[k] = {i_roll_b[k], i_cnt_b[k*CNT_W +: CNT_W],
                               i_roll_a[k], i_cnt_a[k*CNT_W +: CNT_W]};
        end
    endgenerate

    // Priority encoder: the loop runs upward so the highest set bit wins.
    always_comb begin
        w_sel_ch = '0;
        for (int k = 0; k < N_CH-1; k++) begin
            if (i_sel[k]) begin
                w_sel_ch = CH_W'(k + 1);
            end
        end
    end

    always_comb begin
        case (i_mode)
            2'd1:    w_req_fam = c_FAM_SCAN;
            2'd2:    w_req_fam = c_FAM_SNAP;
            default: w_req_fam = c_FAM_DIRECT;
        endcase
        case (r_state_q)
            ST_SCAN:      w_cur_fam = c_FAM_SCAN;
            ST_SNAP_IDLE: w_cur_fam = c_FAM_SNAP;
            ST_SNAP_HOLD: w_cur_fam = c_FAM_SNAP;
            default:      w_cur_fam = c_FAM_DIRECT;
        endcase
    end

    // A dwell of 0 behaves as 1. Using >= rather than == makes a shortened
    // dwell advance at once when the counter is already past the new limit.
    assign w_dwell_last = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);
    assign w_dwell_done = (r_dwell_q >= w_dwell_last);

    always_comb begin
        w_state_d = r_state_q;
        w_idx_d   = r_idx_q;
        w_dwell_d = r_dwell_q;
        w_data_d  = r_data_q;
        w_ch_d    = r_ch_q;
        w_valid_d = r_valid_q;
        w_ovf_d   = r_ovf_q;

        if (w_req_fam != w_cur_fam) begin
            // Mode change: enter the new family cleanly. The payload holds.
            case (w_req_fam)
                c_FAM_SCAN: w_state_d = ST_SCAN;
                c_FAM_SNAP: w_state_d = ST_SNAP_IDLE;
                default:    w_state_d = ST_DIRECT;
            endcase
            w_idx_d   = '0;
            w_dwell_d = '0;
            w_valid_d = 1'b0;
            w_ovf_d   = 1'b0;
        end else begin
            case (r_state_q)
                ST_DIRECT: begin
                    w_data_d  = w_pay[w_sel_ch];
                    w_ch_d    = w_sel_ch;
                    w_valid_d = 1'b1;
                end
                ST_SCAN: begin
                    w_data_d  = w_pay[r_idx_q];
                    w_ch_d    = r_idx_q;
                    // A zero dwell count marks the first cycle on a channel.
                    w_valid_d = (r_dwell_q == '0);
                    if (w_dwell_done) begin
                        w_dwell_d = '0;
                        w_idx_d   = (r_idx_q == CH_W'(N_CH-1)) ? '0
                                                               : r_idx_q + CH_W'(1);
                    end else begin
                        w_dwell_d = r_dwell_q + DWELL_W'(1);
                    end
                end
                ST_SNAP_IDLE: begin
                    w_valid_d = 1'b0;
                    if (i_req) begin
                        w_data_d  = w_pay[w_sel_ch];
                        w_ch_d    = w_sel_ch;
                        w_valid_d = 1'b1;
                        w_state_d = ST_SNAP_HOLD;
                    end
                end
                ST_SNAP_HOLD: begin
                    // A request while a snapshot is held is lost, even when
                    // the consumer releases the held snapshot in this cycle.
                    if (i_req) begin
                        w_ovf_d = 1'b1;
                    end
                    if (i_ready) begin
                        w_valid_d = 1'b0;
                        w_state_d = ST_SNAP_IDLE;
                    end
                end
                default: begin
                    w_state_d = ST_DIRECT;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= ST_DIRECT;
            r_idx_q   <= '0;
            r_dwell_q <= '0;
            r_data_q  <= '0;
            r_ch_q    <= '0;
            r_valid_q <= 1'b0;
            r_ovf_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_dwell_q <= w_dwell_d;
            r_data_q  <= w_data_d;
            r_ch_q    <= w_ch_d;
            r_valid_q <= w_valid_d;
            r_ovf_q   <= w_ovf_d;
        end
    end

    assign o_data  = r_data_q;
    assign o_ch    = r_ch_q;
    assign o_valid = r_valid_q;
    assign o_ovf   = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan
// Description : Self-checking bench for mux_scan. A mode-level reference
//               model predicts the registered outputs every cycle. Directed
//               steps also check hand-computed literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan;

    localparam int c_N  = 7;
    localparam int c_W  = 5;
    localparam int c_DW = 8;
    localparam int c_CW = $clog2(c_N);
    localparam int c_PW = 2*c_W + 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           mode;
    logic [c_N-2:0]       sel;
    logic [c_DW-1:0]      dwell;
    logic [c_N-1:0]       roll_a, roll_b;
    logic [c_N*c_W-1:0]   cnt_a, cnt_b;
    logic                 req, ready;
    logic [c_PW-1:0]      o_data;
    logic [c_CW-1:0]      o_ch;
    logic                 o_valid, o_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    mux_scan #(.N_CH(c_N), .CNT_W(c_W), .DWELL_W(c_DW)) dut (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel), .i_dwell(dwell),
        .i_roll_a(roll_a), .i_roll_b(roll_b), .i_cnt_a(cnt_a), .i_cnt_b(cnt_b),
        .i_req(req), .i_ready(ready),
        .o_data(o_data), .o_ch(o_ch), .o_valid(o_valid), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int k, input int a, input int b, input bit ra, input bit rb);
        cnt_a[k*c_W +: c_W] = c_W'(a);
        cnt_b[k*c_W +: c_W] = c_W'(b);
        roll_a[k] = ra;
        roll_b[k] = rb;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [c_PW-1:0] m_pay(input int ch);
        return {roll_b[ch], cnt_b[ch*c_W +: c_W], roll_a[ch], cnt_a[ch*c_W +: c_W]};
    endfunction

    function automatic int m_sel(input logic [c_N-2:0] s);
        int r = 0;
        for (int k = 0; k < c_N-1; k++) if (s[k]) r = k + 1;
        return r;
    endfunction

    function automatic int m_family(input logic [1:0] m);
        return (m == 2'd1) ? 1 : (m == 2'd2) ? 2 : 0;
    endfunction

    bit              m_ok = 0;
    int              m_fam = 0;       // 0 direct, 1 scan, 2 snapshot
    int              m_t = 0;         // cycles spent scanning since entry
    bit              m_hold = 0;      // a snapshot is being presented
    logic [c_PW-1:0] e_data;
    int              e_ch;
    bit              e_valid, e_ovf;

    always @(posedge clk) begin : model
        int d, c;
        if (rst) begin
            m_ok <= 1; m_fam <= 0; m_t <= 0; m_hold <= 0;
            e_data <= '0; e_ch <= 0; e_valid <= 0; e_ovf <= 0;
        end else if (m_ok) begin
            if (m_family(mode) != m_fam) begin
                m_fam <= m_family(mode); m_t <= 0; m_hold <= 0;
                e_valid <= 0; e_ovf <= 0;
            end else if (m_fam == 0) begin
                e_data <= m_pay(m_sel(sel)); e_ch <= m_sel(sel); e_valid <= 1;
            end else if (m_fam == 1) begin
                d = (dwell == 0) ? 1 : int'(dwell);
                c = (m_t / d) % c_N;
                e_data <= m_pay(c); e_ch <= c; e_valid <= ((m_t % d) == 0);
                m_t <= m_t + 1;
            end else if (!m_hold) begin
                e_valid <= 0;
                if (req) begin
                    e_data <= m_pay(m_sel(sel)); e_ch <= m_sel(sel);
                    e_valid <= 1; m_hold <= 1;
                end
            end else begin
                if (req) e_ovf <= 1;
                if (ready) begin e_valid <= 0; m_hold <= 0; end
            end
        end
    end

    always @(posedge clk) begin : compare
        #1;
        if (m_ok) begin
            chk("cyc_data",  32'(o_data),  32'(e_data));
            chk("cyc_ch",    32'(o_ch),    32'(e_ch));
            chk("cyc_valid", 32'(o_valid), 32'(e_valid));
            chk("cyc_ovf",   32'(o_ovf),   32'(e_ovf));
        end
    end

    // ---------------- directed stimulus ----------------
    int scan_seq [22] = '{0,0,0,1,1,1,2,2,2,3,3,3,4,4,4,5,5,5,6,6,6,0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1; mode = 0; sel = '0; dwell = '0; req = 0; ready = 0;
        cnt_a = '0; cnt_b = '0; roll_a = '0; roll_b = '0;
        for (int k = 1; k < c_N; k++) set_ch(k, 3*k + 1, 31 - k, k[0], k[1]);
        set_ch(0, 'h15, 'h0A, 1, 0);
        repeat (2) @(negedge clk);
        chk("rst_data",  32'(o_data), 0);
        chk("rst_ch",    32'(o_ch), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_ovf",   32'(o_ovf), 0);

        // Direct mode
        rst = 0;
        @(negedge clk);
        chk("dir_ch0_data", 32'(o_data), 32'h2B5);
        chk("dir_ch0_ch", 32'(o_ch), 0);
        chk("dir_ch0_valid", 32'(o_valid), 1);
        sel = 6'b010100;
        @(negedge clk);
        chk("dir_sel5", 32'(o_ch), 5);
        sel = 6'b100000;
        @(negedge clk);
        chk("dir_sel6", 32'(o_ch), 6);
        chk("dir_sel6_data", 32'(o_data), 32'hE53);
        mode = 2'd3; sel = 6'b000001;
        @(negedge clk);
        chk("mode3_ch", 32'(o_ch), 1);
        chk("mode3_valid", 32'(o_valid), 1);

        // Scan, dwell 3
        mode = 2'd1; dwell = 8'd3;
        @(negedge clk);
        chk("scan_entry_valid", 32'(o_valid), 0);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            chk("scan3_ch", 32'(o_ch), 32'(scan_seq[i]));
            chk("scan3_valid", 32'(o_valid), 32'((i % 3) == 0));
        end

        // Scan, dwell 0 (re-entered through direct)
        mode = 2'd0; dwell = 8'd0;
        @(negedge clk);
        mode = 2'd1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("scan0_ch", 32'(o_ch), 32'(i % 7));
            chk("scan0_valid", 32'(o_valid), 1);
        end

        // Snapshot
        mode = 2'd2; sel = 6'b000010;
        @(negedge clk);
        chk("snap_entry_valid", 32'(o_valid), 0);
        req = 1;
        @(negedge clk);
        req = 0;
        chk("snap_cap_valid", 32'(o_valid), 1);
        chk("snap_cap_ch", 32'(o_ch), 2);
        chk("snap_cap_data", 32'(o_data), 32'hF47);
        set_ch(2, 0, 0, 1, 0);
        repeat (2) @(negedge clk);
        chk("snap_frozen", 32'(o_data), 32'hF47);
        chk("snap_hold_valid", 32'(o_valid), 1);
        req = 1;
        @(negedge clk);
        req = 0;
        chk("snap_ovf_set", 32'(o_ovf), 1);
        chk("snap_ovf_data", 32'(o_data), 32'hF47);
        ready = 1;
        @(negedge clk);
        ready = 0;
        chk("snap_release", 32'(o_valid), 0);
        chk("snap_ovf_sticky", 32'(o_ovf), 1);
        @(negedge clk);
        chk("snap_idle_data", 32'(o_data), 32'hF47);
        mode = 2'd0;
        @(negedge clk);
        chk("ovf_clear", 32'(o_ovf), 0);

        // Reset mid-scan at channel 4
        mode = 2'd1; dwell = 8'd3;
        repeat (15) @(negedge clk);
        chk("midscan_ch4", 32'(o_ch), 4);
        rst = 1;
        @(negedge clk);
        chk("midrst_data", 32'(o_data), 0);
        chk("midrst_ch", 32'(o_ch), 0);
        chk("midrst_valid", 32'(o_valid), 0);
        rst = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("restart_ch", 32'(o_ch), 32'(scan_seq[i]));
            chk("restart_valid", 32'(o_valid), 32'((i % 3) == 0));
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
